// File: rtl/dvk_sdram_pkg.sv
// Shared definitions for the SDRAM Wishbone-style bridge.
// Contents: bridge FSM state encoding, default parameter values and the
// widths of the three hold counters (reset hold-off, ack delay, timeout).
package dvk_sdram_pkg;

  typedef enum logic [2:0] {
    StHold = 3'd0,
    StInit = 3'd1,
    StIdle = 3'd2,
    StReq  = 3'd3,
    StAckd = 3'd4,
    StDone = 3'd5
  } state_e;

  localparam int unsigned DefAw       = 21;
  localparam int unsigned DefCaw      = 22;
  localparam int unsigned DefRstDelay = 3;
  localparam int unsigned DefAckDelay = 2;
  localparam int unsigned DefTimeout  = 255;

  // Counter widths cover the legal parameter ranges (1..15, 1..7, 1..1023).
  localparam int unsigned HoldCntW = 4;
  localparam int unsigned AckCntW  = 3;
  localparam int unsigned ToCntW   = 10;

endpackage

// File: rtl/sdram_hold_counter.sv
// Reload/decrement counter used for the reset hold-off, ack delay and timeout.
// Ports:
//   clk_p    - clock
//   load     - reload count with load_val (has priority over dec)
//   load_val - reload value
//   dec      - decrement by one, saturating at zero
//   last     - count currently equals 1, i.e. this decrement reaches zero
module sdram_hold_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk_p,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_p) begin
    count_q <= count_d;
  end

  assign last = (count_q == W'(1));

endmodule

// File: rtl/sdram_wb_bridge.sv
// Bridge between the processor-side SDRAM bus (stb/we/sel/adr/ack) and the
// sdram_top request/acknowledge controller.
// Ports:
//   clk_p, reset              - clock, synchronous active-high reset
//   wb_stb/we/sel/adr/dat_i   - bus request side
//   wb_dat_o, wb_ack          - registered read data, gated acknowledge
//   ready                     - controller initialised, bridge accepting
//   ctl_rst_n, ctl_init_done  - controller reset (held off) and init status
//   ctl_wr_req/rd_req         - controller requests, held until acked
//   ctl_wr_ack/rd_ack         - controller acknowledges
//   ctl_addr/wdata/byteen     - latched request fields
//   ctl_rdata                 - controller read data
//   dqm                       - DRAM data masks {UDQM, LDQM}, 1 = masked
//   timeout_err               - sticky request-timeout flag
module sdram_wb_bridge
  import dvk_sdram_pkg::*;
#(
  parameter int unsigned AW        = DefAw,
  parameter int unsigned CAW       = DefCaw,
  parameter int unsigned RST_DELAY = DefRstDelay,
  parameter int unsigned ACK_DELAY = DefAckDelay,
  parameter int unsigned TIMEOUT   = DefTimeout
) (
  input  logic           clk_p,
  input  logic           reset,
  input  logic           wb_stb,
  input  logic           wb_we,
  input  logic [1:0]     wb_sel,
  input  logic [AW-1:0]  wb_adr,
  input  logic [15:0]    wb_dat_i,
  output logic [15:0]    wb_dat_o,
  output logic           wb_ack,
  output logic           ready,
  output logic           ctl_rst_n,
  input  logic           ctl_init_done,
  output logic           ctl_wr_req,
  output logic           ctl_rd_req,
  input  logic           ctl_wr_ack,
  input  logic           ctl_rd_ack,
  output logic [CAW-1:0] ctl_addr,
  output logic [15:0]    ctl_wdata,
  input  logic [15:0]    ctl_rdata,
  output logic [1:0]     ctl_byteen,
  output logic [1:0]     dqm,
  output logic           timeout_err
);

  state_e         state_q, state_d;
  logic [CAW-1:0] addr_q, addr_d;
  logic [15:0]    wdata_q, wdata_d;
  logic [15:0]    rdata_q, rdata_d;
  logic [1:0]     sel_q, sel_d;
  logic [1:0]     dqm_q, dqm_d;
  logic           we_q, we_d;
  logic           abort_q, abort_d;
  logic           ack_flag_q, ack_flag_d;
  logic           terr_q, terr_d;

  logic hold_last, ack_last, to_last;
  logic ack_match;

  sdram_hold_counter #(.W(HoldCntW)) u_hold_cnt (
    .clk_p    (clk_p),
    .load     (reset),
    .load_val (HoldCntW'(RST_DELAY)),
    .dec      (state_q == StHold),
    .last     (hold_last)
  );

  sdram_hold_counter #(.W(AckCntW)) u_ack_cnt (
    .clk_p    (clk_p),
    .load     (state_q != StAckd),
    .load_val (AckCntW'(ACK_DELAY)),
    .dec      (state_q == StAckd),
    .last     (ack_last)
  );

  sdram_hold_counter #(.W(ToCntW)) u_to_cnt (
    .clk_p    (clk_p),
    .load     (state_q != StReq),
    .load_val (ToCntW'(TIMEOUT)),
    .dec      (state_q == StReq),
    .last     (to_last)
  );

  // Only the ack matching the outstanding request type counts.
  assign ack_match = we_q ? ctl_wr_ack : ctl_rd_ack;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    sel_d      = sel_q;
    dqm_d      = dqm_q;
    we_d       = we_q;
    abort_d    = abort_q;
    ack_flag_d = ack_flag_q;
    terr_d     = terr_q;

    unique case (state_q)
      StHold: begin
        if (hold_last) state_d = StInit;
      end
      StInit: begin
        if (ctl_init_done) state_d = StIdle;
      end
      StIdle: begin
        if (wb_stb) begin
          addr_d     = CAW'(wb_adr);
          wdata_d    = wb_dat_i;
          sel_d      = wb_sel;
          we_d       = wb_we;
          dqm_d      = wb_we ? ~wb_sel : 2'b00;
          abort_d    = 1'b0;
          ack_flag_d = 1'b0;
          state_d    = StReq;
        end
      end
      StReq: begin
        if (ack_match) begin
          if (!we_q) rdata_d = ctl_rdata;
          // A strobe dropping in the ack cycle itself also counts as abort.
          state_d = (abort_q || !wb_stb) ? StIdle : StAckd;
        end else if (to_last) begin
          terr_d  = 1'b1;
          state_d = StDone;
        end else if (!wb_stb) begin
          // The controller cannot cancel, so keep requesting until acked.
          abort_d = 1'b1;
        end
      end
      StAckd: begin
        if (!wb_stb) begin
          state_d = StIdle;
        end else if (ack_last) begin
          ack_flag_d = 1'b1;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (!wb_stb) begin
          ack_flag_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StHold;
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (reset) begin
      state_q    <= StHold;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      sel_q      <= '0;
      dqm_q      <= '0;
      we_q       <= 1'b0;
      abort_q    <= 1'b0;
      ack_flag_q <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      sel_q      <= sel_d;
      dqm_q      <= dqm_d;
      we_q       <= we_d;
      abort_q    <= abort_d;
      ack_flag_q <= ack_flag_d;
      terr_q     <= terr_d;
    end
  end

  assign ctl_rst_n   = (state_q != StHold);
  assign ready       = (state_q == StIdle) || (state_q == StReq) ||
                       (state_q == StAckd) || (state_q == StDone);
  // Requests are also gated by reset so they drop without waiting for the edge.
  assign ctl_wr_req  = (state_q == StReq) && we_q && !reset;
  assign ctl_rd_req  = (state_q == StReq) && !we_q && !reset;
  assign wb_ack      = (state_q == StDone) && wb_stb && ack_flag_q;
  assign wb_dat_o    = rdata_q;
  assign ctl_addr    = addr_q;
  assign ctl_wdata   = wdata_q;
  assign ctl_byteen  = sel_q;
  assign dqm         = dqm_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_sdram_wb_bridge.sv
module tb_sdram_wb_bridge;

  localparam int unsigned AW  = 21;
  localparam int unsigned CAW = 22;

  logic           clk_p;
  logic           reset;
  logic           wb_stb;
  logic           wb_we;
  logic [1:0]     wb_sel;
  logic [AW-1:0]  wb_adr;
  logic [15:0]    wb_dat_i;
  logic [15:0]    wb_dat_o;
  logic           wb_ack;
  logic           ready;
  logic           ctl_rst_n;
  logic           ctl_init_done;
  logic           ctl_wr_req;
  logic           ctl_rd_req;
  logic           ctl_wr_ack;
  logic           ctl_rd_ack;
  logic [CAW-1:0] ctl_addr;
  logic [15:0]    ctl_wdata;
  logic [15:0]    ctl_rdata;
  logic [1:0]     ctl_byteen;
  logic [1:0]     dqm;
  logic           timeout_err;

  int checks = 0;
  int errors = 0;

  sdram_wb_bridge #(
    .AW        (AW),
    .CAW       (CAW),
    .RST_DELAY (3),
    .ACK_DELAY (2),
    .TIMEOUT   (8)
  ) dut (
    .clk_p         (clk_p),
    .reset         (reset),
    .wb_stb        (wb_stb),
    .wb_we         (wb_we),
    .wb_sel        (wb_sel),
    .wb_adr        (wb_adr),
    .wb_dat_i      (wb_dat_i),
    .wb_dat_o      (wb_dat_o),
    .wb_ack        (wb_ack),
    .ready         (ready),
    .ctl_rst_n     (ctl_rst_n),
    .ctl_init_done (ctl_init_done),
    .ctl_wr_req    (ctl_wr_req),
    .ctl_rd_req    (ctl_rd_req),
    .ctl_wr_ack    (ctl_wr_ack),
    .ctl_rd_ack    (ctl_rd_ack),
    .ctl_addr      (ctl_addr),
    .ctl_wdata     (ctl_wdata),
    .ctl_rdata     (ctl_rdata),
    .ctl_byteen    (ctl_byteen),
    .dqm           (dqm),
    .timeout_err   (timeout_err)
  );

  initial clk_p = 1'b0;
  always #5 clk_p = ~clk_p;

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk_p);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) step();
    checks++; if (ctl_rst_n !== 1'b0) begin errors++; $display("FAIL rst_ctl_rst_n: got %b want 0", ctl_rst_n); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ready); end
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL rst_wb_ack: got %b want 0", wb_ack); end
    checks++; if ({ctl_wr_req, ctl_rd_req} !== 2'b00) begin errors++; $display("FAIL rst_reqs: got %b want 00", {ctl_wr_req, ctl_rd_req}); end
    checks++; if (dqm !== 2'b00) begin errors++; $display("FAIL rst_dqm: got %b want 00", dqm); end
    checks++; if (wb_dat_o !== 16'h0000) begin errors++; $display("FAIL rst_dat_o: got %h want 0000", wb_dat_o); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_terr: got %b want 0", timeout_err); end
    checks++; if ({ctl_addr, ctl_wdata, ctl_byteen} !== '0) begin errors++; $display("FAIL rst_latched: got %h/%h/%b want 0", ctl_addr, ctl_wdata, ctl_byteen); end
    reset = 1'b0;  // first cycle with reset low
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (ctl_rst_n !== (i == 3)) begin errors++; $display("FAIL holdoff_c%0d: got %b want %b", i, ctl_rst_n, (i == 3)); end
    end
    repeat (7) step();
    ctl_init_done = 1'b1;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL init_ready_before: got %b want 0", ready); end
    step();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL init_ready_after: got %b want 1", ready); end
  endtask

  task automatic test_byte_write();
    wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 2'b10; wb_adr = 21'h12345; wb_dat_i = 16'hA55A;
    step();  // cycle 1: request
    checks++; if (ctl_wr_req !== 1'b1 || ctl_rd_req !== 1'b0) begin errors++; $display("FAIL bw_req: got wr=%b rd=%b want 1/0", ctl_wr_req, ctl_rd_req); end
    checks++; if (ctl_addr !== 22'h012345) begin errors++; $display("FAIL bw_addr: got %h want 012345", ctl_addr); end
    checks++; if (dqm !== 2'b01) begin errors++; $display("FAIL bw_dqm: got %b want 01", dqm); end
    checks++; if (ctl_byteen !== 2'b10) begin errors++; $display("FAIL bw_byteen: got %b want 10", ctl_byteen); end
    checks++; if (ctl_wdata !== 16'hA55A) begin errors++; $display("FAIL bw_wdata: got %h want a55a", ctl_wdata); end
    for (int i = 2; i <= 5; i++) begin
      step();
      checks++; if (ctl_wr_req !== 1'b1 || wb_ack !== 1'b0) begin errors++; $display("FAIL bw_wait_c%0d: got req=%b ack=%b want 1/0", i, ctl_wr_req, wb_ack); end
    end
    ctl_wr_ack = 1'b1;  // ack sampled in cycle 5
    step();
    ctl_wr_ack = 1'b0;
    checks++; if (ctl_wr_req !== 1'b0 || wb_ack !== 1'b0) begin errors++; $display("FAIL bw_c6: got req=%b ack=%b want 0/0", ctl_wr_req, wb_ack); end
    step();
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL bw_c7_ack: got %b want 0", wb_ack); end
    step();
    checks++; if (wb_ack !== 1'b1) begin errors++; $display("FAIL bw_c8_ack: got %b want 1", wb_ack); end
    wb_stb = 1'b0;
    #1;
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL bw_ack_drop: got %b want 0", wb_ack); end
    step();
  endtask

  task automatic test_read();
    wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 2'b11; wb_adr = 21'h00ABC;
    step();  // cycle 1
    checks++; if (ctl_rd_req !== 1'b1 || ctl_wr_req !== 1'b0) begin errors++; $display("FAIL rd_req: got rd=%b wr=%b want 1/0", ctl_rd_req, ctl_wr_req); end
    checks++; if (dqm !== 2'b00) begin errors++; $display("FAIL rd_dqm: got %b want 00", dqm); end
    ctl_wr_ack = 1'b1;  // wrong-type ack must be ignored
    step();  // cycle 2
    ctl_wr_ack = 1'b0;
    checks++; if (ctl_rd_req !== 1'b1) begin errors++; $display("FAIL rd_wrong_ack: got %b want 1", ctl_rd_req); end
    ctl_rd_ack = 1'b1; ctl_rdata = 16'hBEEF;
    step();  // cycle 3
    ctl_rd_ack = 1'b0; ctl_rdata = 16'h0000;
    checks++; if (wb_dat_o !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h want beef", wb_dat_o); end
    checks++; if (ctl_rd_req !== 1'b0 || wb_ack !== 1'b0) begin errors++; $display("FAIL rd_c3: got req=%b ack=%b want 0/0", ctl_rd_req, wb_ack); end
    step();
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL rd_c4_ack: got %b want 0", wb_ack); end
    step();
    checks++; if (wb_ack !== 1'b1) begin errors++; $display("FAIL rd_c5_ack: got %b want 1", wb_ack); end
    step();
    checks++; if (wb_ack !== 1'b1 || wb_dat_o !== 16'hBEEF) begin errors++; $display("FAIL rd_hold: got ack=%b dat=%h want 1/beef", wb_ack, wb_dat_o); end
    wb_stb = 1'b0;
    #1;
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_drop: got %b want 0", wb_ack); end
    step();
    checks++; if (wb_dat_o !== 16'hBEEF) begin errors++; $display("FAIL rd_data_stable: got %h want beef", wb_dat_o); end
  endtask

  task automatic test_abort();
    wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 2'b01; wb_adr = 21'h1F0F0; wb_dat_i = 16'h1111;
    step();  // cycle 1: REQ entry
    step();  // cycle 2
    wb_stb = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      step();
      checks++; if (ctl_wr_req !== 1'b1 || wb_ack !== 1'b0) begin errors++; $display("FAIL ab_hold_c%0d: got req=%b ack=%b want 1/0", i, ctl_wr_req, wb_ack); end
    end
    ctl_wr_ack = 1'b1;  // ack in cycle 5
    step();  // cycle 6: should be IDLE
    ctl_wr_ack = 1'b0;
    checks++; if (ctl_wr_req !== 1'b0 || wb_ack !== 1'b0) begin errors++; $display("FAIL ab_c6: got req=%b ack=%b want 0/0", ctl_wr_req, wb_ack); end
    wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 2'b11; wb_adr = 21'h00777;
    step();  // cycle 7: accepted only if cycle 6 was IDLE
    checks++; if (ctl_rd_req !== 1'b1 || ctl_addr !== 22'h000777) begin errors++; $display("FAIL ab_next_accept: got req=%b addr=%h want 1/000777", ctl_rd_req, ctl_addr); end
    ctl_rd_ack = 1'b1; ctl_rdata = 16'h1234;
    step();
    ctl_rd_ack = 1'b0;
    checks++; if (wb_dat_o !== 16'h1234) begin errors++; $display("FAIL ab_next_data: got %h want 1234", wb_dat_o); end
    step();
    step();
    checks++; if (wb_ack !== 1'b1) begin errors++; $display("FAIL ab_next_ack: got %b want 1", wb_ack); end
    wb_stb = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 2'b11; wb_adr = 21'h00042; wb_dat_i = 16'h5678;
    step();  // cycle 1: REQ entry
    for (int i = 1; i <= 8; i++) begin
      checks++; if (ctl_wr_req !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_wait_c%0d: got req=%b err=%b want 1/0", i, ctl_wr_req, timeout_err); end
      step();
    end
    checks++; if (ctl_wr_req !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_fire: got req=%b err=%b want 0/1", ctl_wr_req, timeout_err); end
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL to_ack_fire: got %b want 0", wb_ack); end
    step();
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL to_ack_after: got %b want 0", wb_ack); end
    wb_stb = 1'b0;
    repeat (4) step();
    checks++; if (timeout_err !== 1'b1 || ready !== 1'b1) begin errors++; $display("FAIL to_sticky: got err=%b ready=%b want 1/1", timeout_err, ready); end
  endtask

  task automatic test_reset_mid();
    wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 2'b11; wb_adr = 21'h00005;
    step();  // cycle 1: REQ
    checks++; if (ctl_rd_req !== 1'b1) begin errors++; $display("FAIL rm_req: got %b want 1", ctl_rd_req); end
    reset = 1'b1; ctl_init_done = 1'b0;
    step();
    checks++; if (ctl_rd_req !== 1'b0 || ctl_rst_n !== 1'b0) begin errors++; $display("FAIL rm_drop: got req=%b rst_n=%b want 0/0", ctl_rd_req, ctl_rst_n); end
    checks++; if (ready !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rm_state: got ready=%b err=%b want 0/0", ready, timeout_err); end
    checks++; if (ctl_addr !== 22'h0 || wb_dat_o !== 16'h0) begin errors++; $display("FAIL rm_cleared: got addr=%h dat=%h want 0/0", ctl_addr, wb_dat_o); end
    reset = 1'b0; wb_stb = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (ctl_rst_n !== (i == 3)) begin errors++; $display("FAIL rm_holdoff_c%0d: got %b want %b", i, ctl_rst_n, (i == 3)); end
    end
    ctl_init_done = 1'b1;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rm_ready_before: got %b want 0", ready); end
    step();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rm_ready_after: got %b want 1", ready); end
  endtask

  initial begin
    reset = 1'b1; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = 2'b00; wb_adr = '0; wb_dat_i = '0;
    ctl_init_done = 1'b0; ctl_wr_ack = 1'b0; ctl_rd_ack = 1'b0; ctl_rdata = '0;
    test_reset();
    test_byte_write();
    test_read();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
